// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory bus between fetch and data ports
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [ADDR_W-1:0]     i_req_addr,
    output logic                  i_resp_valid,
    output logic [31:0]           i_resp_data,
    input  logic                  d_req_valid,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_write,
    input  logic [DATA_W-1:0]     d_req_wdata,
    input  logic [DATA_W/8-1:0]   d_req_strobe,
    output logic                  d_resp_valid,
    output logic [DATA_W-1:0]     d_resp_data,
    output logic                  bus_req_valid,
    output logic [ADDR_W-1:0]     bus_req_addr,
    output logic                  bus_req_write,
    output logic [DATA_W-1:0]     bus_req_wdata,
    output logic [DATA_W/8-1:0]   bus_req_strobe,
    input  logic                  bus_req_ready,
    input  logic                  bus_resp_valid,
    input  logic [DATA_W-1:0]     bus_resp_data,
    input  logic                  flush
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_owner;
    logic                  r_last_owner;
    logic                  r_drop;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_write;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_strobe;
    logic [DATA_W-1:0]     r_data;
    logic                  w_fetch_req;
    logic                  w_grant;
    logic                  w_grant_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_fetch_req  = i_req_valid && !flush;
        w_grant      = w_fetch_req || d_req_valid;
        w_grant_data = d_req_valid;
        if (w_fetch_req && d_req_valid) begin
            w_grant_data = (r_last_owner == OWN_FETCH);
        end

        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_next = S_REQ;
            S_REQ:   if (bus_req_ready) w_next = S_WAIT;
            S_WAIT:  if (bus_resp_valid) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_FETCH;
            r_last_owner <= OWN_DATA;
            r_drop       <= 1'b0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_strobe     <= '0;
            r_data       <= '0;
        end else begin
            if (r_state == S_IDLE && w_grant) begin
                if (w_grant_data) begin
                    r_owner  <= OWN_DATA;
                    r_addr   <= d_req_addr;
                    r_write  <= d_req_write;
                    r_wdata  <= d_req_wdata;
                    r_strobe <= d_req_strobe;
                end else begin
                    r_owner  <= OWN_FETCH;
                    r_addr   <= i_req_addr;
                    r_write  <= 1'b0;
                    r_wdata  <= '0;
                    r_strobe <= '0;
                end
            end

            if (r_state == S_WAIT && bus_resp_valid) begin
                r_data <= bus_resp_data;
            end

            // A redirected fetch still runs to completion on the bus; only its reply is discarded.
            if (r_state == S_RESP) begin
                r_drop       <= 1'b0;
                r_last_owner <= r_owner;
            end else if (r_state != S_IDLE && r_owner == OWN_FETCH && flush) begin
                r_drop <= 1'b1;
            end
        end
    end

    always_comb begin
        bus_req_valid  = (r_state == S_REQ);
        bus_req_addr   = r_addr;
        bus_req_write  = r_write;
        bus_req_wdata  = r_wdata;
        bus_req_strobe = r_strobe;
        // A flush arriving in the response cycle itself also kills the fetch reply.
        i_resp_valid   = (r_state == S_RESP) && (r_owner == OWN_FETCH) && !r_drop && !flush;
        d_resp_valid   = (r_state == S_RESP) && (r_owner == OWN_DATA);
        i_resp_data    = r_addr[2] ? r_data[63:32] : r_data[31:0];
        d_resp_data    = r_data;
    end

endmodule
